// File: rtl/conv_stream_tx.sv
// rtl/conv_stream_tx.sv - host-side AXI-Stream job transmitter (W, bias, X) for the conv accelerator input
// Define CONV_TX_TLAST_EN to add the TX_TLAST output on the final X beat of each job.
module conv_stream_tx #(
  parameter int INW  = 18,
  parameter int R    = 9,
  parameter int C    = 8,
  parameter int MAXK = 5,
  localparam int K_BITS = $clog2(MAXK + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_we,
  input  logic                    load_sel,
  input  logic [$clog2(R*C)-1:0]  load_addr,
  input  logic [INW-1:0]          load_data,
  input  logic                    start,
  input  logic [K_BITS-1:0]       start_k,
  input  logic                    start_new_w,
  input  logic [INW-1:0]          start_bias,
  output logic                    busy,
  output logic                    done,
  output logic [INW-1:0]          TX_TDATA,
  output logic                    TX_TVALID,
  output logic [K_BITS:0]         TX_TUSER,
`ifdef CONV_TX_TLAST_EN
  output logic                    TX_TLAST,
`endif
  input  logic                    TX_TREADY
);

  localparam int XA    = $clog2(R*C);
  localparam int WA    = $clog2(MAXK*MAXK);
  localparam int KK_W  = 2*K_BITS;
  localparam int MINRC = (R < C) ? R : C;
  localparam logic [K_BITS-1:0] K_LIMIT = K_BITS'((MAXK < MINRC) ? MAXK : MINRC);
  localparam logic [XA-1:0]     X_LAST  = XA'(R*C - 1);
  localparam logic [WA-1:0]     W_LAST  = WA'(MAXK*MAXK - 1);

  typedef enum logic [2:0] {IDLE, SEND_W, SEND_B, SEND_X, FINISH} state_t;
  typedef enum logic [1:0] {SRC_W, SRC_B, SRC_X} src_t;

  state_t state, state_nx, seg;
  logic [K_BITS-1:0] k_r, cur_k;
  logic [INW-1:0]    bias_r;
  logic [WA-1:0]     w_cnt, w_cnt_nx, w_cur;
  logic [XA-1:0]     x_cnt, x_cnt_nx, x_cur;
  logic              x_all, x_all_nx;
  logic [KK_W-1:0]   kk_m1;

  logic [INW-1:0] x_mem [R*C];
  logic [INW-1:0] w_mem [MAXK*MAXK];
  logic [INW-1:0] x_q, w_q;
  logic           x_we, w_we;

  logic           start_ok, pop, room, issue, iss_last;
  src_t           iss_src, fl_src;
  logic           fl_vld;
  logic [2:0]     occ;

  // Two-entry output queue; e0 is the presented beat.
  logic [1:0]     cnt;
  logic [INW-1:0] e0_data, e1_data, land_data;
  logic           e0_w, e1_w, land_w;
  logic           e0_ld, e0_from_e1, e1_ld;

  assign TX_TVALID = (cnt != 2'd0);
  assign TX_TDATA  = e0_data;
  assign TX_TUSER  = {k_r, e0_w};

  assign x_we = load_we && !busy && !load_sel && (load_addr <= X_LAST);
  assign w_we = load_we && !busy && load_sel && (load_addr[WA-1:0] <= W_LAST);

  // Write-first forwarding lets a job accepted in the same cycle as a load see the new word.
  always_ff @(posedge clk) begin
    if (x_we) x_mem[load_addr] <= load_data;
    if (w_we) w_mem[load_addr[WA-1:0]] <= load_data;
    x_q <= (x_we && load_addr == x_cur) ? load_data : x_mem[x_cur];
    w_q <= (w_we && load_addr[WA-1:0] == w_cur) ? load_data : w_mem[w_cur];
  end

  always_comb begin
    start_ok = start && (state == IDLE) && (start_k != '0) && (start_k <= K_LIMIT);
    pop      = TX_TVALID && TX_TREADY;
    occ      = {1'b0, cnt} + {2'b00, fl_vld};
    room     = (occ - {2'b00, pop}) < 3'd2;
    cur_k    = (state == IDLE) ? start_k : k_r;
    kk_m1    = KK_W'(cur_k) * KK_W'(cur_k) - KK_W'(1);
    w_cur    = (state == IDLE) ? '0 : w_cnt;
    x_cur    = (state == IDLE) ? '0 : x_cnt;
    seg      = state;
    if (state == IDLE) seg = start_new_w ? SEND_W : SEND_X;

    state_nx = state;
    w_cnt_nx = w_cnt;
    x_cnt_nx = x_cnt;
    x_all_nx = x_all;
    issue    = 1'b0;
    iss_src  = SRC_X;
    iss_last = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nx = seg;
          w_cnt_nx = '0;
          x_cnt_nx = '0;
          x_all_nx = 1'b0;
          issue    = 1'b1;
        end
      end
      SEND_W, SEND_B: begin
        busy  = 1'b1;
        issue = room;
      end
      SEND_X: begin
        busy  = 1'b1;
        issue = room && !x_all;
        if (x_all && !fl_vld && cnt == 2'd1 && pop) state_nx = FINISH;
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Reads run ahead of the handshake; each issue advances the segment counters.
    if (issue) begin
      case (seg)
        SEND_W: begin
          iss_src = SRC_W;
          if (KK_W'(w_cur) == kk_m1) begin
            w_cnt_nx = '0;
            state_nx = SEND_B;
          end else begin
            w_cnt_nx = w_cur + WA'(1);
          end
        end
        SEND_B: begin
          iss_src  = SRC_B;
          state_nx = SEND_X;
        end
        default: begin
          iss_src  = SRC_X;
          iss_last = (x_cur == X_LAST);
          if (iss_last) begin
            x_cnt_nx = '0;
            x_all_nx = 1'b1;
          end else begin
            x_cnt_nx = x_cur + XA'(1);
          end
        end
      endcase
    end

    land_data  = (fl_src == SRC_B) ? bias_r : ((fl_src == SRC_W) ? w_q : x_q);
    land_w     = (fl_src != SRC_X);
    e0_from_e1 = pop && (cnt == 2'd2);
    e0_ld      = e0_from_e1 || (fl_vld && ((cnt == 2'd0) || (cnt == 2'd1 && pop)));
    e1_ld      = fl_vld && ((cnt == 2'd1 && !pop) || (cnt == 2'd2 && pop));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      w_cnt   <= '0;
      x_cnt   <= '0;
      x_all   <= 1'b0;
      k_r     <= '0;
      bias_r  <= '0;
      fl_vld  <= 1'b0;
      fl_src  <= SRC_X;
      cnt     <= 2'd0;
      e0_data <= '0;
      e0_w    <= 1'b0;
      e1_data <= '0;
      e1_w    <= 1'b0;
    end else begin
      state  <= state_nx;
      w_cnt  <= w_cnt_nx;
      x_cnt  <= x_cnt_nx;
      x_all  <= x_all_nx;
      fl_vld <= issue;
      if (issue) fl_src <= iss_src;
      if (start_ok) begin
        k_r    <= start_k;
        bias_r <= start_bias;
      end
      if (e0_ld) begin
        e0_data <= e0_from_e1 ? e1_data : land_data;
        e0_w    <= e0_from_e1 ? e1_w : land_w;
      end
      if (e1_ld) begin
        e1_data <= land_data;
        e1_w    <= land_w;
      end
      cnt <= cnt + {1'b0, fl_vld} - {1'b0, pop};
    end
  end

`ifdef CONV_TX_TLAST_EN
  logic fl_last, e0_last, e1_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      fl_last <= 1'b0;
      e0_last <= 1'b0;
      e1_last <= 1'b0;
    end else begin
      if (issue) fl_last <= iss_last;
      if (e0_ld) e0_last <= e0_from_e1 ? e1_last : fl_last;
      if (e1_ld) e1_last <= fl_last;
    end
  end

  assign TX_TLAST = TX_TVALID && e0_last;
`endif

endmodule
